dmem_multicycle: RTL and testbench
==================================

# dmem_multicycle

Multi-cycle data-memory responder for the MEM stage of the pipelined 16-bit CPU. It serves the stage's memory requests (enable/wr/addr/data_in) with a fixed configurable latency and raises `busy` so the hazard unit can stall the pipeline until the access completes. It replaces the single-cycle data memory in the stall-capable build.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: word-index width; array depth is 2^ADDR_WIDTH 16-bit words.
- `LATENCY`, 4: cycles from request acceptance to completion; legal range 2..15.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `enable`  in  1: request strobe from the MEM stage.
- `wr`  in  1: 1 = write, 0 = read; qualified by `enable`.
- `addr`  in  16: byte address; word index = `addr[ADDR_WIDTH:1]`; `addr[0]` and the bits above the index are ignored.
- `data_in`  in  16: write data.
- `data_out`  out  16: read data; holds the last completed read.
- `data_valid`  out  1: one-cycle completion pulse.
- `busy`  out  1: a request is in flight; the MEM stage must stall.

## Operation
- States: IDLE, WAIT, DONE. A request is accepted on a rising edge when the state is IDLE or DONE and `enable`=1.
- On acceptance: register `addr`, `wr` and `data_in`; load the counter with `LATENCY`-1; go to WAIT.
- In WAIT, decrement the counter each cycle. When the counter reaches 1, the edge commits the access and moves to DONE:
  - Write: store the registered data at the registered word index.
  - Read: load `data_out` from the array.
- In DONE, `data_valid`=1 and `busy`=0. On the next edge, go to WAIT if `enable`=1 (back-to-back request), otherwise go to IDLE.
- `enable`, `wr`, `addr` and `data_in` are ignored while in WAIT. The pipeline is stalled and holds them stable, but the block does not depend on that.
- Read after write to the same word: the write commits before the later read samples the array, so the read returns the new data.
- Array contents are not cleared by reset and are X until written.

## Timing
- The request is sampled at the edge ending cycle T.
- Cycles T+1 .. T+LATENCY-1: WAIT, `busy`=1.
- Cycle T+LATENCY: DONE, `data_valid`=1, and read data is present on `data_out`.
- Maximum throughput is one request per `LATENCY` cycles.
- Reset values: state IDLE, `busy`=0, `data_valid`=0, `data_out`=16'h0000, counter 0.
- Reset asserted mid-operation aborts the request. A pending write is discarded, no `data_valid` is produced, and `data_out` clears.
- If `rst` and `enable` are high on the same edge, reset wins and the request is dropped.

## Configuration
- Macro: `DMEM_WRITE_ACK_EN`.
- Defined: writes also pulse `data_valid` in DONE; `data_out` is unchanged by writes.
- Undefined: `data_valid` pulses only for reads. Writes still pass through WAIT and DONE with identical `busy` timing.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE, WAIT, DONE);
  - `DMEM_LATENCY_DEFAULT` = 4;
  - `DMEM_WORD_W` = 16.
- Sub-module `dmem_array`: a 2^ADDR_WIDTH x 16 array with a synchronous write port and a synchronous read port, both gated by a commit strobe. No reset on its contents.
- The top level holds the FSM, the latency counter, the request registers and the `data_out` register.

## Test plan
- Reset, then idle: all outputs 0; `enable`=0 for 10 cycles -> `busy` and `data_valid` stay 0.
- Write 16'hBEEF to addr 16'h0010 at T, then read 16'h0010 -> `busy` high for cycles T+1..T+3; the read completes 4 cycles after its acceptance with `data_out`=16'hBEEF and `data_valid`=1 for exactly one cycle.
- Back-to-back: hold `enable`=1 through DONE with a read of 16'h0011 (the same word as 16'h0010) -> a new request is accepted in the DONE cycle, returns 16'hBEEF, and the `addr[0]` alias is confirmed.
- Changing `addr` and `data_in` during WAIT -> no effect on the in-flight access or the array.
- Reset asserted at T+2 of a write of 16'h1234 to 16'h0020 -> no `data_valid`; a later read of 16'h0020 returns the prior contents, not 16'h1234.
- With `DMEM_WRITE_ACK_EN` defined, a write pulses `data_valid` at T+LATENCY and `data_out` is unchanged; without it, no pulse. Repeat both with `LATENCY`=2.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the multi-cycle data memory responder:
//   - dmem_state_e         : responder FSM states (IDLE, WAIT, DONE)
//   - DMEM_LATENCY_DEFAULT : default request-to-completion latency in cycles
//   - DMEM_WORD_W          : data word width
//   - DMEM_BYTE_ADDR_W     : width of the byte address presented by the MEM stage
//   - dmem_latency_ok()    : legal-range helper for the LATENCY parameter
package dmem_pkg;

  localparam int DMEM_LATENCY_DEFAULT = 4;
  localparam int DMEM_WORD_W          = 16;
  localparam int DMEM_BYTE_ADDR_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // LATENCY must fit the 4-bit countdown and leave at least one WAIT cycle.
  function automatic bit dmem_latency_ok(input int lat);
    return (lat >= 2) && (lat <= 15);
  endfunction

endpackage

// File: rtl/dmem_multicycle_if.sv
// dmem_multicycle_if
// Request/response bundle between the MEM stage and the data memory.
//   enable     : request strobe (MEM stage -> memory)
//   wr         : 1 = write, 0 = read, qualified by enable
//   addr       : byte address; the memory uses the word index bits only
//   data_in    : write data
//   data_out   : read data, holds the last completed read
//   data_valid : one-cycle completion pulse
//   busy       : request in flight, MEM stage must stall
//
// Handshake: a request is taken on any rising edge where enable=1 and the
// memory is not busy. While busy=1 the request fields are ignored. Completion
// is signalled by a single-cycle data_valid pulse (reads always, writes only
// when write acknowledges are built in); busy is low in that cycle so a new
// request can be taken on the same edge that ends it.
interface dmem_multicycle_if;
  import dmem_pkg::*;

  logic                        enable;
  logic                        wr;
  logic [DMEM_BYTE_ADDR_W-1:0] addr;
  logic [DMEM_WORD_W-1:0]      data_in;
  logic [DMEM_WORD_W-1:0]      data_out;
  logic                        data_valid;
  logic                        busy;

  // MEM stage side
  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy
  );

  // Memory side
  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array
// 2^ADDR_WIDTH x DMEM_WORD_W storage with one synchronous port that either
// writes or reads, only on the cycle the commit strobe is high. Contents and
// the read register have no reset; the owner masks rdata_o until a read has
// actually completed.
//   clk      : clock
//   commit_i : perform the access on this rising edge
//   we_i     : 1 = write wdata_i, 0 = read into rdata_o
//   idx_i    : word index
//   wdata_i  : write data
//   rdata_o  : data from the last committed read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   commit_i,
  input  logic                   we_i,
  input  logic [ADDR_WIDTH-1:0]  idx_i,
  input  logic [DMEM_WORD_W-1:0] wdata_i,
  output logic [DMEM_WORD_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DMEM_WORD_W-1:0] mem_q [DEPTH];
  logic [DMEM_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (commit_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (commit_i && !we_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_multicycle.sv
// dmem_multicycle
// Multi-cycle data memory for the MEM stage of the stall-capable 16-bit CPU.
// A request is registered, held in WAIT for LATENCY-1 cycles (busy=1), then
// committed to the array; the following DONE cycle reports completion.
//
// Parameters:
//   ADDR_WIDTH : word-index width (array depth 2^ADDR_WIDTH), at most 15
//   LATENCY    : request acceptance to completion in cycles, 2..15
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset, aborts any in-flight request
//   bus         : dmem_multicycle_if slave (enable/wr/addr/data_in in,
//                 data_out/data_valid/busy out)
//   dbg_state_o : current FSM state
// Build option:
//   DMEM_WRITE_ACK_EN : when defined, completed writes also pulse data_valid;
//                       otherwise data_valid pulses for reads only.
module dmem_multicycle
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int LATENCY    = DMEM_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  dmem_multicycle_if.slave bus,
  output dmem_state_e      dbg_state_o
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic                   rd_vld_q;   // data_out shows array data only after a read completed since reset
  logic [DMEM_WORD_W-1:0] rdata;
  logic                   accept;
  logic                   commit;

  // Requests are taken from IDLE and from DONE (back-to-back).
  assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.enable;

  // The last WAIT edge performs the access; reset on that edge discards it.
  assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd1) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.enable) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Request fields are captured only on acceptance, so anything the
      // MEM stage does to them during WAIT cannot disturb the access.
      if (accept) begin
        wr_q    <= bus.wr;
        idx_q   <= bus.addr[ADDR_WIDTH:1];
        wdata_q <= bus.data_in;
      end
      if (commit && !wr_q) begin
        rd_vld_q <= 1'b1;
      end
    end
  end

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk      (clk),
    .commit_i (commit),
    .we_i     (wr_q),
    .idx_i    (idx_q),
    .wdata_i  (wdata_q),
    .rdata_o  (rdata)
  );

  assign bus.data_out = rd_vld_q ? rdata : '0;
  assign bus.busy     = (state_q == ST_WAIT);

`ifdef DMEM_WRITE_ACK_EN
  assign bus.data_valid = (state_q == ST_DONE);
`else
  assign bus.data_valid = (state_q == ST_DONE) && !wr_q;
`endif

  assign dbg_state_o = state_q;

  // addr[0] and the bits above the word index do not select anything.
  if (ADDR_WIDTH < DMEM_BYTE_ADDR_W - 1) begin : g_unused_hi
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[0], bus.addr[DMEM_BYTE_ADDR_W-1:ADDR_WIDTH+1]};
  end else begin : g_unused_lo
    logic unused_addr_bits;
    assign unused_addr_bits = bus.addr[0];
  end

endmodule

// File: tb/tb_dmem_multicycle.sv
// tb_dmem_multicycle
// Drives two responders (LATENCY 4 and LATENCY 2) with the same request
// stream. A transaction-level model decides from the documented timing when
// each instance takes a request, what it must return and in which cycle;
// expected completions are queued at acceptance and popped by a monitor on
// the falling edge. Honors DMEM_WRITE_ACK_EN in the model.
module tb_dmem_multicycle;
  import dmem_pkg::*;

  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;
  localparam int LAT_A = 4;
  localparam int LAT_B = 2;
  localparam int EW    = 49;   // {chk, done_cycle[31:0], data[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en   = 1'b0;
  logic        wr   = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] din  = '0;

  dmem_multicycle_if bus_a ();
  dmem_multicycle_if bus_b ();

  assign bus_a.enable  = en;
  assign bus_a.wr      = wr;
  assign bus_a.addr    = addr;
  assign bus_a.data_in = din;
  assign bus_b.enable  = en;
  assign bus_b.wr      = wr;
  assign bus_b.addr    = addr;
  assign bus_b.data_in = din;

  dmem_state_e dbg_a, dbg_b;

  dmem_multicycle #(.ADDR_WIDTH(AW), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state_o(dbg_a)
  );
  dmem_multicycle #(.ADDR_WIDTH(AW), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state_o(dbg_b)
  );

  // ---------------- model state ----------------
  int          n_vec    = 0;
  int          n_miscmp = 0;
  int          cyc      = 0;
  bit          mon_on   = 1'b0;
  int          lat [2]  = '{LAT_A, LAT_B};
  logic [EW-1:0] exp_q_a [$];
  logic [EW-1:0] exp_q_b [$];
  logic [15:0] mdl   [2][DEPTH];
  bit          known [2][DEPTH];
  bit          pend    [2];
  int          acc     [2];
  bit          pwr     [2];
  int          pidx    [2];
  logic [15:0] pdat    [2];
  logic [15:0] last_rd [2] = '{16'h0000, 16'h0000};

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic logic [EW-1:0] q_front(input int k);
    if (k == 0) return exp_q_a[0];
    return exp_q_b[0];
  endfunction

  function automatic logic [EW-1:0] q_pop(input int k);
    if (k == 0) return exp_q_a.pop_front();
    return exp_q_b.pop_front();
  endfunction

  task automatic q_push(input int k, input logic [EW-1:0] e);
    if (k == 0) exp_q_a.push_back(e);
    else        exp_q_b.push_back(e);
  endtask

  task automatic q_clear(input int k);
    if (k == 0) exp_q_a.delete();
    else        exp_q_b.delete();
  endtask

  task automatic chk16(input string nm, input int k, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miscmp++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, k, cyc, act, expv);
    end
  endtask

  // Edge ending cycle `cyc`: reset aborts; an in-flight access completes on
  // the edge ending cycle acc+LATENCY-1; a free instance takes enable=1.
  task automatic model_step(input int k);
    bit free;
    logic [15:0] rd;
    if (rst) begin
      pend[k]    = 1'b0;
      last_rd[k] = 16'h0000;
      q_clear(k);
    end else begin
      free = !pend[k];
      if (pend[k] && (cyc == acc[k] + lat[k] - 1)) begin
        if (pwr[k]) begin
          mdl[k][pidx[k]]   = pdat[k];
          known[k][pidx[k]] = 1'b1;
        end else begin
          last_rd[k] = known[k][pidx[k]] ? mdl[k][pidx[k]] : 16'hxxxx;
        end
        pend[k] = 1'b0;
      end
      if (free && en) begin
        acc[k]  = cyc;
        pend[k] = 1'b1;
        pwr[k]  = wr;
        pidx[k] = int'(addr[AW:1]);
        pdat[k] = din;
        if (!wr) begin
          rd = mdl[k][pidx[k]];
          q_push(k, {known[k][pidx[k]], 32'(cyc + lat[k]), rd});
        end
`ifdef DMEM_WRITE_ACK_EN
        else begin
          q_push(k, {!$isunknown(last_rd[k]), 32'(cyc + lat[k]), last_rd[k]});
        end
`endif
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      cyc++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_step(input int k, input logic busy, input logic dv, input logic [15:0] dout);
    logic [EW-1:0] e;
    bit exp_dv;
    chk16("busy", k, {15'b0, busy}, {15'b0, pend[k]});
    if (!$isunknown(last_rd[k])) chk16("data_out", k, dout, last_rd[k]);
    exp_dv = 1'b0;
    if (q_size(k) > 0) begin
      e = q_front(k);
      exp_dv = (int'(e[47:16]) == cyc);
    end
    chk16("data_valid", k, {15'b0, dv}, {15'b0, exp_dv});
    if (exp_dv) begin
      e = q_pop(k);
      if (e[48] && dv === 1'b1) chk16("done_data", k, dout, e[15:0]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        mon_step(0, bus_a.busy, bus_a.data_valid, bus_a.data_out);
        mon_step(1, bus_b.busy, bus_b.data_valid, bus_b.data_out);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free();
    int n = 0;
    while ((pend[0] || pend[1]) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_miscmp++;
      $display("FAIL wait_free cycle %0d: still busy after %0d cycles, required idle", cyc, n);
    end
  endtask

  // One-cycle request, then junk on the request fields while it is in flight.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    wait_free();
    en = 1'b1; wr = w; addr = a; din = d;
    tick();
    en = 1'b0; wr = 1'($urandom_range(0, 1)); addr = 16'($urandom); din = 16'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    tick();
    mon_on = 1'b1;
    repeat (2) tick();
    chk16("dbg_state_a", 0, 16'(dbg_a), 16'(ST_IDLE));
    chk16("dbg_state_b", 1, 16'(dbg_b), 16'(ST_IDLE));
    rst = 1'b0;
    repeat (10) tick();

    // write then read back
    issue(1'b1, 16'h0010, 16'hBEEF);
    issue(1'b0, 16'h0010, 16'h0000);

    // back-to-back reads, second one via the addr[0] alias
    wait_free();
    en = 1'b1; wr = 1'b0; addr = 16'h0010;
    tick();
    addr = 16'h0011;
    repeat (6) tick();
    en = 1'b0;

    // request fields changing while in flight
    issue(1'b1, 16'h0042, 16'h0A0A);
    issue(1'b1, 16'h0040, 16'h55AA);
    addr = 16'h0042; din = 16'hDEAD; wr = 1'b1;
    repeat (2) tick();
    issue(1'b0, 16'h0040, 16'h0000);
    issue(1'b0, 16'h0042, 16'h0000);

    // reset two cycles into a write
    issue(1'b1, 16'h0020, 16'h0F0F);
    wait_free();
    en = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'h1234;
    tick();
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(1'b0, 16'h0020, 16'h0000);

    // reset and enable on the same edge
    wait_free();
    rst = 1'b1; en = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'h7777;
    tick();
    rst = 1'b0; en = 1'b0;
    issue(1'b0, 16'h0020, 16'h0000);

    // fill the random working set
    for (int i = 0; i <= 16; i++) begin
      issue(1'b1, 16'(i << 1), 16'($urandom));
    end

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = {2'($urandom_range(0, 3)), 13'($urandom_range(0, 16)), 1'($urandom_range(0, 1))};
      din  = 16'($urandom);
      tick();
    end
    rst = 1'b0; en = 1'b0;

    repeat (20) tick();
    chk16("drain_q_a", 0, 16'(exp_q_a.size()), 16'h0000);
    chk16("drain_q_b", 1, 16'(exp_q_b.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
